store_buffer: RTL and testbench

Posted-write store buffer between the pipelined core's memory stage and the data RAM. It accepts each word store from the core in the cycle it is issued and queues it in a circular FIFO. Queued stores drain to the RAM write port whenever the RAM grants a write slot. Loads read the RAM directly; the youngest matching buffered store overrides the RAM data, so the core's view of memory stays coherent.

---
 rtl/store_buffer.sv | 125 ++++++++++++
 tb/tb_store_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
// Posted-write store buffer between the core memory stage and the data RAM.
// Word stores are queued in a circular FIFO and drained in order whenever the
// RAM grants a write slot. Loads read the RAM directly; when built with the
// STORE_BUFFER_FWD_EN macro, the youngest matching buffered store overrides
// the RAM read data.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   MemWriteM             store strobe from the memory stage
//   ALUResultM[31:0]      byte address for loads/stores (bits [1:0] ignored)
//   WriteDataM[31:0]      store data
//   ReadDataM[31:0]       load data to the core (combinational)
//   MemRAddr[AW-1:0]      RAM read word address
//   MemRData[31:0]        RAM asynchronous read data
//   MemWE                 RAM write request (buffer not empty)
//   MemWAddr/MemWData     head entry presented to the RAM write port
//   MemWReady             RAM write grant
//   Empty/Full            occupancy flags
//   Overflow              sticky: a store was dropped on a full buffer
//
// Configuration macro: STORE_BUFFER_FWD_EN (store-to-load forwarding).
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic [31:0]   ALUResultM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic [AW-1:0] MemRAddr,
  input  logic [31:0]   MemRData,
  output logic          MemWE,
  output logic [AW-1:0] MemWAddr,
  output logic [31:0]   MemWData,
  input  logic          MemWReady,
  output logic          Empty,
  output logic          Full,
  output logic          Overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_unused_alu;

  // Byte-offset bits are not part of the word address.
  assign w_unused_alu = ^ALUResultM;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && MemWReady;
  // A pop on the same edge frees the slot, so a full buffer still accepts.
  assign w_push  = MemWriteM && (!w_full || w_pop);
  assign w_drop  = MemWriteM && w_full && !w_pop;

  // Pointer, count and overflow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry storage; contents are left unreset since count gates validity.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_addr[r_tail] <= ALUResultM[AW+1:2];
      r_data[r_tail] <= WriteDataM;
    end
  end

  assign MemRAddr = ALUResultM[AW+1:2];
  assign MemWE    = !w_empty;
  assign MemWAddr = r_addr[r_head];
  assign MemWData = r_data[r_head];
  assign Empty    = w_empty;
  assign Full     = w_full;
  assign Overflow = r_overflow;

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] w_idx;

  // Walk valid entries oldest to youngest; the last hit wins, which is the
  // same result as a backward search from tail-1 that stops at first match.
  always_comb begin
    ReadDataM = MemRData;
    w_idx     = r_head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == MemRAddr)) begin
        ReadDataM = r_data[w_idx];
      end
    end
  end
`else
  assign ReadDataM = MemRData;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 30;

  logic          clk = 1'b0;
  logic          tb_reset = 1'b1;
  logic          tb_we = 1'b0;
  logic [31:0]   tb_alu = 32'h0;
  logic [31:0]   tb_wdata = 32'h0;
  logic          tb_rdy = 1'b0;
  logic [31:0]   tb_rdata;

  logic [31:0]   ReadDataM;
  logic [AW-1:0] MemRAddr;
  logic          MemWE;
  logic [AW-1:0] MemWAddr;
  logic [31:0]   MemWData;
  logic          Empty;
  logic          Full;
  logic          Overflow;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Synthetic RAM read data derived from the bench's own address.
  assign tb_rdata = 32'hC0DE_0000 ^ {2'b00, tb_alu[31:2]};

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (tb_reset),
    .MemWriteM  (tb_we),
    .ALUResultM (tb_alu),
    .WriteDataM (tb_wdata),
    .ReadDataM  (ReadDataM),
    .MemRAddr   (MemRAddr),
    .MemRData   (tb_rdata),
    .MemWE      (MemWE),
    .MemWAddr   (MemWAddr),
    .MemWData   (MemWData),
    .MemWReady  (tb_rdy),
    .Empty      (Empty),
    .Full       (Full),
    .Overflow   (Overflow)
  );

  // Behavioural model: a queue of pending stores plus a sticky overflow bit.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf = 1'b0;

  always @(posedge clk) begin
    bit pop;
    ent_t e;
    if (tb_reset) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (mq.size() > 0) && tb_rdy;
      if (pop) void'(mq.pop_front());
      if (tb_we) begin
        if (mq.size() < DEPTH) begin
          e.a = tb_alu[AW+1:2];
          e.d = tb_wdata;
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = tb_rdata;
`ifdef STORE_BUFFER_FWD_EN
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == tb_alu[AW+1:2]) begin
        r = mq[i].d;
        break;
      end
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_empty", 64'(Empty), 64'(mq.size() == 0));
      chk("m_full", 64'(Full), 64'(mq.size() == DEPTH));
      chk("m_ovf", 64'(Overflow), 64'(m_ovf));
      chk("m_we", 64'(MemWE), 64'(mq.size() != 0));
      chk("m_raddr", 64'(MemRAddr), 64'(tb_alu[AW+1:2]));
      chk("m_rdata", 64'(ReadDataM), 64'(exp_rdata()));
      if (mq.size() != 0) begin
        chk("m_waddr", 64'(MemWAddr), 64'(mq[0].a));
        chk("m_wdata", 64'(MemWData), 64'(mq[0].d));
      end
    end
  end

  task automatic step(input bit r, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy);
    @(posedge clk);
    #1;
    tb_reset = r;
    tb_we    = we;
    tb_alu   = a;
    tb_wdata = d;
    tb_rdy   = rdy;
    @(negedge clk);
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    // Reset then idle.
    @(posedge clk);
    #1 chk_en = 1'b1;
    step(1, 0, 32'h0, 32'h0, 0);
    step(0, 0, 32'h300, 32'h0, 0);
    chk("rst_empty", 64'(Empty), 64'd1);
    chk("rst_full", 64'(Full), 64'd0);
    chk("rst_ovf", 64'(Overflow), 64'd0);
    chk("rst_we", 64'(MemWE), 64'd0);
    chk("idle_rdata", 64'(ReadDataM), 64'h0000_0000_C0DE_00C0);

    // Single store drains the next cycle.
    step(0, 1, 32'h100, 32'hDEADBEEF, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    chk("st_we", 64'(MemWE), 64'd1);
    chk("st_waddr", 64'(MemWAddr), 64'h40);
    chk("st_wdata", 64'(MemWData), 64'h0000_0000_DEAD_BEEF);
    step(0, 0, 32'h0, 32'h0, 1);
    chk("st_empty", 64'(Empty), 64'd1);

    // Two stores to one address; youngest forwards.
    step(0, 1, 32'h200, 32'h11, 0);
    step(0, 1, 32'h200, 32'h22, 0);
    step(0, 0, 32'h200, 32'h0, 0);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_young", 64'(ReadDataM), 64'h22);
`else
    chk("fwd_young", 64'(ReadDataM), 64'h0000_0000_C0DE_0080);
`endif
    chk("fwd_head", 64'(MemWData), 64'h11);
    step(0, 0, 32'h204, 32'h0, 0);
    chk("fwd_miss", 64'(ReadDataM), 64'h0000_0000_C0DE_0081);
    step(0, 0, 32'h0, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 0);
    chk("fwd_drained", 64'(Empty), 64'd1);

    // Fill, overflow on a fifth store, then drain in order.
    for (int i = 0; i < 4; i++) step(0, 1, 32'h10 + 32'(4 * i), 32'(i + 1), 0);
    step(0, 0, 32'h0, 32'h0, 0);
    chk("fill_full", 64'(Full), 64'd1);
    chk("fill_ovf0", 64'(Overflow), 64'd0);
    step(0, 1, 32'h20, 32'h5, 0);
    step(0, 0, 32'h0, 32'h0, 0);
    chk("ovf_full", 64'(Full), 64'd1);
    chk("ovf_set", 64'(Overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 32'h0, 1);
      chk("ovf_drain", 64'(MemWData), 64'(i + 1));
    end
    step(0, 0, 32'h0, 32'h0, 0);
    chk("ovf_empty", 64'(Empty), 64'd1);
    chk("ovf_sticky", 64'(Overflow), 64'd1);

    // Full with simultaneous pop: push accepted, new entry drains last.
    step(1, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h10 + 32'(4 * i), 32'(i + 1), 0);
    step(0, 1, 32'h40, 32'h99, 1);
    step(0, 0, 32'h0, 32'h0, 0);
    chk("fp_full", 64'(Full), 64'd1);
    chk("fp_ovf", 64'(Overflow), 64'd0);
    drain_exp[0] = 32'h2;
    drain_exp[1] = 32'h3;
    drain_exp[2] = 32'h4;
    drain_exp[3] = 32'h99;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 32'h0, 1);
      chk("fp_order", 64'(MemWData), 64'(drain_exp[i]));
    end
    step(0, 0, 32'h0, 32'h0, 0);
    chk("fp_empty", 64'(Empty), 64'd1);

    // Reset mid-drain discards pending stores.
    for (int i = 0; i < 3; i++) step(0, 1, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i), 0);
    step(1, 0, 32'h0, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    chk("rd_empty", 64'(Empty), 64'd1);
    chk("rd_we", 64'(MemWE), 64'd0);
    step(0, 0, 32'h84, 32'h0, 1);
    chk("rd_we2", 64'(MemWE), 64'd0);
    chk("rd_rdata", 64'(ReadDataM), 64'h0000_0000_C0DE_0021);

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
